// File: rtl/vend_pkg.sv
// Shared types and default sizing for the vending-machine credit path.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CREDIT = 2'd1,
    PAYOUT = 2'd2
  } state_t;

  localparam int unsigned CURRENCY_WIDTH_DEF = 7;
  localparam int unsigned NUM_CH_DEF         = 2;
  localparam int unsigned MAX_TOTAL_DEF      = 100;

endpackage

// File: rtl/coin_accept_chain.sv
// Combinational priority chain: channels are admitted lowest index first
// against a running sum that never exceeds MAX_TOTAL.
module coin_accept_chain
  import vend_pkg::*;
#(
  parameter int unsigned CURRENCY_WIDTH = CURRENCY_WIDTH_DEF,
  parameter int unsigned NUM_CH         = NUM_CH_DEF,
  parameter int unsigned MAX_TOTAL      = MAX_TOTAL_DEF
) (
  input  logic [CURRENCY_WIDTH-1:0]        base,
  input  logic [NUM_CH*CURRENCY_WIDTH-1:0] values,
  input  logic [NUM_CH-1:0]                valids,
  input  logic                             enable,
  output logic [NUM_CH-1:0]                accept,
  output logic [CURRENCY_WIDTH-1:0]        sum
);

  localparam logic [CURRENCY_WIDTH:0] CAP = (CURRENCY_WIDTH+1)'(MAX_TOTAL);

  logic [CURRENCY_WIDTH:0] run;
  logic [CURRENCY_WIDTH:0] cand;

  // One extra bit on the adder keeps an over-cap sum from wrapping into range.
  always_comb begin
    run    = {1'b0, base};
    cand   = '0;
    accept = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cand = run + {1'b0, values[i*CURRENCY_WIDTH +: CURRENCY_WIDTH]};
      if (enable && valids[i] && (cand <= CAP)) begin
        accept[i] = 1'b1;
        run       = cand;
      end
    end
    sum = run[CURRENCY_WIDTH-1:0];
  end

endmodule

// File: rtl/currency_accum_mc.sv
// Multi-channel credit accumulator: sums coins up to a cap, resolves vend and
// refund requests, and hands change to the payout mechanism via valid/ready.
module currency_accum_mc
  import vend_pkg::*;
#(
  parameter int unsigned CURRENCY_WIDTH = CURRENCY_WIDTH_DEF,
  parameter int unsigned NUM_CH         = NUM_CH_DEF,
  parameter int unsigned MAX_TOTAL      = MAX_TOTAL_DEF
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic [NUM_CH*CURRENCY_WIDTH-1:0] coin_value,
  input  logic [NUM_CH-1:0]                coin_valid,
  output logic [NUM_CH-1:0]                coin_reject,
  input  logic                             vend_req,
  input  logic [CURRENCY_WIDTH-1:0]        vend_price,
  output logic                             vend_ok,
  output logic                             vend_denied,
  input  logic                             refund_req,
  output logic [CURRENCY_WIDTH-1:0]        change_value,
  output logic                             change_valid,
  input  logic                             change_ready,
  output logic [CURRENCY_WIDTH-1:0]        total_currency,
  output logic                             currency_avail
);

  state_t                    state, state_n;
  logic [CURRENCY_WIDTH-1:0] total, total_n;
  logic [CURRENCY_WIDTH-1:0] change, change_n;
  logic [NUM_CH-1:0]         reject_n;
  logic                      ok_n, denied_n;

  logic                      chain_en;
  logic [NUM_CH-1:0]         accept;
  logic [CURRENCY_WIDTH-1:0] sum;

  // Coins are only summed when nothing else competes for the credit register.
  assign chain_en = (state != PAYOUT) && !vend_req && !refund_req;

  coin_accept_chain #(
    .CURRENCY_WIDTH (CURRENCY_WIDTH),
    .NUM_CH         (NUM_CH),
    .MAX_TOTAL      (MAX_TOTAL)
  ) u_chain (
    .base   (total),
    .values (coin_value),
    .valids (coin_valid),
    .enable (chain_en),
    .accept (accept),
    .sum    (sum)
  );

  always_comb begin
    state_n  = state;
    total_n  = total;
    change_n = change;
    reject_n = coin_valid & ~accept;
    ok_n     = 1'b0;
    denied_n = 1'b0;
    case (state)
      IDLE, CREDIT: begin
        if (refund_req) begin
          if (total != '0) begin
            change_n = total;
            total_n  = '0;
            state_n  = PAYOUT;
          end
        end else if (vend_req) begin
          if (total >= vend_price) begin
            ok_n     = 1'b1;
            change_n = total - vend_price;
            total_n  = '0;
            state_n  = PAYOUT;
          end else begin
            denied_n = 1'b1;
          end
        end else begin
          total_n = sum;
          state_n = (sum != '0) ? CREDIT : IDLE;
        end
      end
      PAYOUT: begin
        if (change_ready) begin
          change_n = '0;
          state_n  = IDLE;
        end
      end
      default: begin
        state_n  = IDLE;
        total_n  = '0;
        change_n = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= IDLE;
      total       <= '0;
      change      <= '0;
      coin_reject <= '0;
      vend_ok     <= 1'b0;
      vend_denied <= 1'b0;
    end else begin
      state       <= state_n;
      total       <= total_n;
      change      <= change_n;
      coin_reject <= reject_n;
      vend_ok     <= ok_n;
      vend_denied <= denied_n;
    end
  end

  assign change_value   = change;
  assign change_valid   = (state == PAYOUT);
  assign total_currency = total;
  assign currency_avail = (total != '0);

endmodule

// File: tb/tb_currency_accum_mc.sv
// Directed vector table followed by randomized traffic against a credit model.
module tb_currency_accum_mc;

  localparam int CW  = 7;
  localparam int NCH = 2;
  localparam int CAP = 100;

  logic              clk = 1'b0;
  logic              rstn;
  logic [NCH*CW-1:0] coin_value;
  logic [NCH-1:0]    coin_valid;
  logic [NCH-1:0]    coin_reject;
  logic              vend_req;
  logic [CW-1:0]     vend_price;
  logic              vend_ok;
  logic              vend_denied;
  logic              refund_req;
  logic [CW-1:0]     change_value;
  logic              change_valid;
  logic              change_ready;
  logic [CW-1:0]     total_currency;
  logic              currency_avail;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  currency_accum_mc #(
    .CURRENCY_WIDTH (CW),
    .NUM_CH         (NCH),
    .MAX_TOTAL      (CAP)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .coin_value     (coin_value),
    .coin_valid     (coin_valid),
    .coin_reject    (coin_reject),
    .vend_req       (vend_req),
    .vend_price     (vend_price),
    .vend_ok        (vend_ok),
    .vend_denied    (vend_denied),
    .refund_req     (refund_req),
    .change_value   (change_value),
    .change_valid   (change_valid),
    .change_ready   (change_ready),
    .total_currency (total_currency),
    .currency_avail (currency_avail)
  );

  typedef struct {
    bit       rstn;
    bit [1:0] cv;
    int       c0;
    int       c1;
    bit       vr;
    int       price;
    bit       rr;
    bit       cr;
    bit [1:0] e_rej;
    bit       e_ok;
    bit       e_den;
    int       e_total;
    bit       e_cv;
    int       e_chg;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit r, bit [1:0] cv, int c0, int c1, bit vr, int price,
                              bit rr, bit cr, bit [1:0] e_rej, bit e_ok, bit e_den,
                              int e_total, bit e_cv, int e_chg);
    vec_t v;
    v.rstn = r; v.cv = cv; v.c0 = c0; v.c1 = c1; v.vr = vr; v.price = price;
    v.rr = rr; v.cr = cr; v.e_rej = e_rej; v.e_ok = e_ok; v.e_den = e_den;
    v.e_total = e_total; v.e_cv = e_cv; v.e_chg = e_chg;
    return v;
  endfunction

  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic drive(bit r, bit [1:0] cv, int c0, int c1, bit vr, int price, bit rr, bit cr);
    rstn         = r;
    coin_valid   = cv;
    coin_value   = {CW'(c1), CW'(c0)};
    vend_req     = vr;
    vend_price   = CW'(price);
    refund_req   = rr;
    change_ready = cr;
  endtask

  task automatic compare(int idx, bit [1:0] e_rej, bit e_ok, bit e_den, int e_total,
                         bit e_cv, int e_chg, bit chg_chk);
    chk("coin_reject", idx, 32'(coin_reject), 32'(e_rej));
    chk("vend_ok", idx, 32'(vend_ok), 32'(e_ok));
    chk("vend_denied", idx, 32'(vend_denied), 32'(e_den));
    chk("total", idx, 32'(total_currency), 32'(e_total));
    chk("avail", idx, 32'(currency_avail), 32'(e_total != 0));
    chk("change_valid", idx, 32'(change_valid), 32'(e_cv));
    if (chg_chk) chk("change_value", idx, 32'(change_value), 32'(e_chg));
  endtask

  // Credit model for random traffic.
  int credit = 0;
  bit paying = 1'b0;
  int owed   = 0;

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    vecs.push_back(mk(0, 2'b00,   0,   0, 0,   0, 0, 0, 2'b00, 0, 0,   0, 0,   0));
    vecs.push_back(mk(0, 2'b00,   0,   0, 0,   0, 0, 0, 2'b00, 0, 0,   0, 0,   0));
    vecs.push_back(mk(1, 2'b01,  10,   0, 0,   0, 0, 0, 2'b00, 0, 0,  10, 0,   0));
    vecs.push_back(mk(1, 2'b10,   0,  25, 0,   0, 0, 0, 2'b00, 0, 0,  35, 0,   0));
    vecs.push_back(mk(1, 2'b00,   0,   0, 0,   0, 1, 0, 2'b00, 0, 0,   0, 1,  35));
    vecs.push_back(mk(1, 2'b00,   0,   0, 0,   0, 0, 1, 2'b00, 0, 0,   0, 0,   0));
    vecs.push_back(mk(1, 2'b11,  60,  50, 0,   0, 0, 0, 2'b10, 0, 0,  60, 0,   0));
    vecs.push_back(mk(1, 2'b01,   5,   0, 0,   0, 0, 0, 2'b00, 0, 0,  65, 0,   0));
    vecs.push_back(mk(1, 2'b00,   0,   0, 1,  50, 0, 0, 2'b00, 1, 0,   0, 1,  15));
    vecs.push_back(mk(1, 2'b00,   0,   0, 0,   0, 0, 0, 2'b00, 0, 0,   0, 1,  15));
    vecs.push_back(mk(1, 2'b01,  10,   0, 0,   0, 0, 0, 2'b01, 0, 0,   0, 1,  15));
    vecs.push_back(mk(1, 2'b00,   0,   0, 1,   3, 1, 0, 2'b00, 0, 0,   0, 1,  15));
    vecs.push_back(mk(1, 2'b00,   0,   0, 0,   0, 0, 1, 2'b00, 0, 0,   0, 0,   0));
    vecs.push_back(mk(1, 2'b01,  30,   0, 0,   0, 0, 0, 2'b00, 0, 0,  30, 0,   0));
    vecs.push_back(mk(1, 2'b00,   0,   0, 1,  50, 0, 0, 2'b00, 0, 1,  30, 0,   0));
    vecs.push_back(mk(1, 2'b00,   0,   0, 0,   0, 1, 0, 2'b00, 0, 0,   0, 1,  30));
    vecs.push_back(mk(1, 2'b00,   0,   0, 0,   0, 0, 1, 2'b00, 0, 0,   0, 0,   0));
    vecs.push_back(mk(1, 2'b01,  40,   0, 0,   0, 0, 0, 2'b00, 0, 0,  40, 0,   0));
    vecs.push_back(mk(1, 2'b00,   0,   0, 1,  10, 1, 0, 2'b00, 0, 0,   0, 1,  40));
    vecs.push_back(mk(0, 2'b00,   0,   0, 0,   0, 0, 0, 2'b00, 0, 0,   0, 0,   0));
    vecs.push_back(mk(1, 2'b00,   0,   0, 0,   0, 0, 0, 2'b00, 0, 0,   0, 0,   0));
    vecs.push_back(mk(1, 2'b01, 100,   0, 0,   0, 0, 0, 2'b00, 0, 0, 100, 0,   0));
    vecs.push_back(mk(1, 2'b01,   0,   0, 0,   0, 0, 0, 2'b00, 0, 0, 100, 0,   0));
    vecs.push_back(mk(1, 2'b01,   1,   0, 0,   0, 0, 0, 2'b01, 0, 0, 100, 0,   0));
    vecs.push_back(mk(1, 2'b00,   0,   0, 1, 100, 0, 0, 2'b00, 1, 0,   0, 1,   0));
    vecs.push_back(mk(1, 2'b00,   0,   0, 0,   0, 0, 1, 2'b00, 0, 0,   0, 0,   0));
    vecs.push_back(mk(1, 2'b00,   0,   0, 0,   0, 1, 0, 2'b00, 0, 0,   0, 0,   0));
    vecs.push_back(mk(1, 2'b01,  20,   0, 1,   5, 0, 0, 2'b01, 0, 1,   0, 0,   0));
    vecs.push_back(mk(1, 2'b11, 127, 127, 0,   0, 0, 0, 2'b11, 0, 0,   0, 0,   0));
    vecs.push_back(mk(1, 2'b11,  70,  30, 0,   0, 0, 0, 2'b00, 0, 0, 100, 0,   0));
    vecs.push_back(mk(1, 2'b10,   0,   9, 0,   0, 1, 0, 2'b10, 0, 0,   0, 1, 100));
    vecs.push_back(mk(1, 2'b00,   0,   0, 0,   0, 0, 1, 2'b00, 0, 0,   0, 0,   0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rstn, vecs[i].cv, vecs[i].c0, vecs[i].c1, vecs[i].vr,
            vecs[i].price, vecs[i].rr, vecs[i].cr);
      @(posedge clk);
      #1;
      compare(i, vecs[i].e_rej, vecs[i].e_ok, vecs[i].e_den, vecs[i].e_total,
              vecs[i].e_cv, vecs[i].e_chg, vecs[i].e_cv || !vecs[i].rstn);
    end

    // Randomized traffic; the DUT is idle with zero credit here.
    for (int n = 0; n < 3000; n++) begin
      bit       r, vr, rr, cr;
      bit [1:0] cv, e_rej;
      int       v[2];
      int       price, sum;
      bit       e_ok, e_den;
      r     = ($urandom_range(0, 99) != 0);
      cv    = 2'($urandom);
      v[0]  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 45));
      v[1]  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 45));
      vr    = ($urandom_range(0, 9) == 0);
      rr    = ($urandom_range(0, 14) == 0);
      price = $urandom_range(0, 110);
      cr    = ($urandom_range(0, 2) == 0);
      drive(r, cv, v[0], v[1], vr, price, rr, cr);

      e_rej = 2'b00;
      e_ok  = 1'b0;
      e_den = 1'b0;
      if (!r) begin
        credit = 0;
        paying = 1'b0;
        owed   = 0;
      end else if (paying) begin
        e_rej = cv;
        if (cr) paying = 1'b0;
      end else if (rr) begin
        e_rej = cv;
        if (credit > 0) begin
          owed   = credit;
          credit = 0;
          paying = 1'b1;
        end
      end else if (vr) begin
        e_rej = cv;
        if (credit >= price) begin
          e_ok   = 1'b1;
          owed   = credit - price;
          credit = 0;
          paying = 1'b1;
        end else begin
          e_den = 1'b1;
        end
      end else begin
        sum = credit;
        for (int k = 0; k < 2; k++) begin
          if (cv[k]) begin
            if (sum + v[k] <= CAP) sum += v[k];
            else e_rej[k] = 1'b1;
          end
        end
        credit = sum;
      end

      @(posedge clk);
      #1;
      compare(1000 + n, e_rej, e_ok, e_den, credit, paying, owed, paying);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
